sirv_uartrx_fifo: RTL
=====================

// Module: sirv_uartrx_fifo
// PURPOSE
//  Parametrised UART receive path: a receiver engine plus an integrated
//  receive FIFO. Supports 5-8 data bits, optional even/odd parity, a
//  majority-vote mid-bit sampler, per-entry framing/parity error flags,
//  a sticky overrun flag and a watermark interrupt.
//  Sits under the UART register front-end, replacing the separate rx engine
//  and rx queue pair.
// PARAMETERS
//  DIV_W       16  width of the baud divisor
//  OVS         16  samples per bit; power of 2, >= 8
//  FIFO_DEPTH   8  rx FIFO entries; power of 2, >= 2
//  CNT_W       $clog2(FIFO_DEPTH)+1  occupancy width (derived, not overridable)
// PORTS
//  clock          in   1      single clock
//  rst_n          in   1      asynchronous active-low reset
//  io_en          in   1      receiver enable
//  io_rxd         in   1      serial input, asynchronous to clock
//  io_div         in   DIV_W  sample tick period = io_div+1 clocks
//  io_nbits       in   2      data bits = 5 + io_nbits
//  io_par_en      in   1      parity bit present
//  io_par_odd     in   1      1 = odd parity, 0 = even parity
//  io_rxwm        in   CNT_W  watermark level
//  io_deq_ready   in   1      consumer pops the head entry
//  io_deq_valid   out  1      FIFO non-empty
//  io_deq_bits    out  8      head data, zero-extended above nbits
//  io_deq_perr    out  1      head entry parity error
//  io_deq_ferr    out  1      head entry framing error
//  io_count       out  CNT_W  FIFO occupancy
//  io_wm_irq      out  1      io_count > io_rxwm (combinational)
//  io_overrun     out  1      sticky: a frame was dropped on full FIFO
//  io_overrun_clr in   1      clears io_overrun
// BEHAVIOUR
//  - Reset: all outputs are 0 except io_deq_bits (0). Sync flops reset to 1. FSM resets to IDLE. FIFO is emptied.
//  - io_rxd passes through a 2-flop synchroniser. Edge detection and sampling use only the synchronised value.
//  - Prescaler: counts from the latched divisor down to 0, then emits a tick and reloads.
//    Sample counter runs mod OVS on each tick. Bit period = OVS*(div+1) clocks.
//  - io_div, io_nbits, io_par_* are latched at start-edge detection. Changes mid-frame do not affect the frame.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: when io_en=1 and a 1->0 edge is seen on the synced rxd, clear the prescaler and sample counter, then go to START.
//  - Bit value = majority of samples OVS/2-1, OVS/2, OVS/2+1.
//    A bit is decided at sample OVS/2+1. The bit ends at sample OVS-1.
//  - START: if the decided value is 1, this is a false start: go to IDLE with no push. Otherwise go to DATA at bit end.
//  - DATA: shift in LSB first, 5+nbits bits. Go to PARITY if par_en, else STOP.
//  - PARITY: perr = XOR(data, parity bit) != par_odd.
//  - STOP: decide at mid-bit; ferr = (value==0). Push {perr,ferr,data} and go to IDLE immediately, without waiting for the bit end.
//    The next start edge is accepted from the cycle after the push.
//  - Frames with errors are still pushed. Only one stop bit is checked.
//  - io_en=0: the FSM returns to IDLE the next cycle. Any partial frame is discarded.
//    FIFO contents and io_overrun are retained. io_deq still works.
//  - FIFO: first-word fall-through. The pushed entry is visible on io_deq_* the cycle after the push cycle.
//    Pop = io_deq_valid & io_deq_ready. io_deq_ready while empty is ignored.
//  - Push is accepted if count<FIFO_DEPTH or a pop occurs in the same cycle.
//    Otherwise the frame is dropped and io_overrun is set the next cycle.
//  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - io_overrun: set and clear in the same cycle -> set wins.
//  - Reset mid-frame: asynchronous return to the reset state.
// TESTING
//  1. 8N1, div=0, OVS=16, frame 0xA5 -> one entry 0xA5, perr=ferr=0.
//     io_deq_valid rises exactly 2+16*9+9 (+/-1) clocks after the rxd fall.
//  2. 7E1, data 0x41 with parity bit 1 (wrong) -> entry 0x41, perr=1, ferr=0.
//     Same frame with parity 0 -> perr=0.
//  3. 8N1, stop bit driven 0 -> entry pushed with ferr=1.
//     The following correctly framed frame 0x3C is received cleanly.
//  4. Low glitch of 3 clocks at div=3 -> false start, count stays 0.
//     A 5N1 frame 0x1F -> entry 0x1F, upper bits 0.
//  5. FIFO_DEPTH=8, push 9 frames (0x00..0x08) without popping -> count=8, io_overrun=1, entries 0x00..0x07.
//     Pop during the 9th push -> no overrun. Then pulse io_overrun_clr -> io_overrun=0.
//  6. rxwm=2: the third entry raises io_wm_irq; one pop drops it.
//     io_en=0 mid-data-bit -> no push; the next frame after io_en=1 is received correctly.

Source files
------------

// File: rtl/sirv_uartrx_fifo_if.sv
// sirv_uartrx_fifo_if: dequeue handshake between the rx FIFO and its consumer.
// The FIFO drives valid/data/flags (master); the consumer drives ready (slave).
interface sirv_uartrx_fifo_if;
    logic       valid;
    logic       ready;
    logic [7:0] bits;
    logic       perr;
    logic       ferr;

    modport master (output valid, output bits, output perr, output ferr, input ready);
    modport slave  (input valid, input bits, input perr, input ferr, output ready);
endinterface

// File: rtl/sirv_uartrx_fifo.sv
// sirv_uartrx_fifo: UART receive engine with an integrated first-word-fall-through
// rx FIFO. Majority-vote mid-bit sampling, per-entry parity/framing flags,
// sticky overrun and a combinational watermark interrupt.
module sirv_uartrx_fifo #(
    parameter  int DIV_W      = 16,
    parameter  int OVS        = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  io_en,
    input  logic                  io_rxd,
    input  logic [DIV_W-1:0]      io_div,
    input  logic [1:0]            io_nbits,
    input  logic                  io_par_en,
    input  logic                  io_par_odd,
    input  logic [CNT_W-1:0]      io_rxwm,
    sirv_uartrx_fifo_if.master    io_deq,
    output logic [CNT_W-1:0]      io_count,
    output logic                  io_wm_irq,
    output logic                  io_overrun,
    input  logic                  io_overrun_clr
);

    localparam int SW = $clog2(OVS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // The sample counter holds the index of the sample most recently taken.
    // On a tick the synchronised input is sample (counter+1), so a tick seen
    // with counter==OVS/2 takes sample OVS/2+1 and decides the bit, and a tick
    // with counter==OVS-1 wraps to sample 0 of the next bit.
    localparam logic [SW-1:0] SMP_A   = SW'(OVS / 2 - 2);
    localparam logic [SW-1:0] SMP_B   = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SMP_DEC = SW'(OVS / 2);
    localparam logic [SW-1:0] SMP_END = SW'(OVS - 1);

    logic              r_rxd_s1, r_rxd_s2, r_rxd_s3;
    logic [2:0]        r_state;
    logic [DIV_W-1:0]  r_pre;
    logic [SW-1:0]     r_smp;
    logic [3:0]        r_bitcnt;
    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_nbits;
    logic              r_par_en;
    logic              r_par_odd;
    logic              r_smp_a;
    logic              r_smp_b;
    logic [7:0]        r_shift;
    logic              r_perr;
    logic [9:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overrun;

    logic              w_fall;
    logic              w_start;
    logic              w_active;
    logic              w_tick;
    logic              w_cap_a;
    logic              w_cap_b;
    logic              w_decide;
    logic              w_bitend;
    logic              w_maj;
    logic [2:0]        w_rsh;
    logic [7:0]        w_data;
    logic [3:0]        w_nbits_tot;
    logic              w_push;
    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;
    logic              w_drop;
    logic [9:0]        w_head;

    assign w_fall      = r_rxd_s3 & ~r_rxd_s2;
    assign w_start     = (r_state == S_IDLE) & io_en & w_fall;
    assign w_active    = (r_state != S_IDLE);
    assign w_tick      = w_active & (r_pre == '0);
    assign w_cap_a     = w_tick & (r_smp == SMP_A);
    assign w_cap_b     = w_tick & (r_smp == SMP_B);
    assign w_decide    = w_tick & (r_smp == SMP_DEC);
    assign w_bitend    = w_tick & (r_smp == SMP_END);
    assign w_maj       = (r_smp_a & r_smp_b) | (r_smp_a & r_rxd_s2) | (r_smp_b & r_rxd_s2);
    // Data bits enter at the MSB, so a short frame sits in the top bits.
    assign w_rsh       = 3'd3 - {1'b0, r_nbits};
    assign w_data      = r_shift >> w_rsh;
    assign w_nbits_tot = 4'd5 + {2'b00, r_nbits};
    assign w_push      = (r_state == S_STOP) & w_decide & io_en;

    assign w_valid     = (r_count != '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop       = w_valid & io_deq.ready;
    assign w_wr        = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & ~w_wr;
    assign w_head      = r_mem[r_rptr];

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_s1 <= 1'b1;
            r_rxd_s2 <= 1'b1;
            r_rxd_s3 <= 1'b1;
        end else begin
            r_rxd_s1 <= io_rxd;
            r_rxd_s2 <= r_rxd_s1;
            r_rxd_s3 <= r_rxd_s2;
        end
    end

    // Frame state machine; dropping io_en abandons any frame in progress
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
        end else if (!io_en) begin
            r_state  <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall) r_state <= S_START;
                end
                S_START: begin
                    if (w_decide && w_maj) begin
                        r_state <= S_IDLE;
                    end else if (w_bitend) begin
                        r_state  <= S_DATA;
                        r_bitcnt <= '0;
                    end
                end
                S_DATA: begin
                    if (w_decide) r_bitcnt <= r_bitcnt + 4'd1;
                    if (w_bitend && (r_bitcnt == w_nbits_tot))
                        r_state <= r_par_en ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    if (w_bitend) r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_decide) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Prescaler and sample counter, restarted on every accepted start edge
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_smp <= '0;
        end else if (w_start) begin
            r_pre <= '0;
            r_smp <= '0;
        end else if (w_active) begin
            if (r_pre == '0) begin
                r_pre <= r_div;
                r_smp <= r_smp + SW'(1);
            end else begin
                r_pre <= r_pre - DIV_W'(1);
            end
        end
    end

    // Frame configuration latch, vote samples, data shifter and parity result
    always_ff @(posedge clock) begin
        if (w_start) begin
            r_div     <= io_div;
            r_nbits   <= io_nbits;
            r_par_en  <= io_par_en;
            r_par_odd <= io_par_odd;
            r_perr    <= 1'b0;
        end
        if (w_cap_a) r_smp_a <= r_rxd_s2;
        if (w_cap_b) r_smp_b <= r_rxd_s2;
        if (w_decide && (r_state == S_DATA)) r_shift <= {w_maj, r_shift[7:1]};
        if (w_decide && (r_state == S_PARITY)) r_perr <= (((^w_data) ^ w_maj) != r_par_odd);
    end

    // FIFO storage: {perr, ferr, data}; a low stop bit is a framing error
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wptr] <= {r_perr, ~w_maj, w_data};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            if (w_wr && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_wr && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (io_overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign io_deq.valid = w_valid;
    assign io_deq.bits  = w_valid ? w_head[7:0] : 8'd0;
    assign io_deq.ferr  = w_valid & w_head[8];
    assign io_deq.perr  = w_valid & w_head[9];
    assign io_count     = r_count;
    assign io_wm_irq    = (r_count > io_rxwm);
    assign io_overrun   = r_overrun;

endmodule
